// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: decodes op/funct and sequences the datapath.
// Drives the ALU opp_code, mux selects, enables and memory requests.
module mips_multicycle_ctrl #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [5:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       ir_en,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ,
        S_MEM_WB, S_MEM_WRITE, S_EXEC_R, S_R_WB,
        S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP
    } state_t;

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [5:0] ALU_AND  = 6'd0;
    localparam logic [5:0] ALU_OR   = 6'd1;
    localparam logic [5:0] ALU_ADD  = 6'd2;
    localparam logic [5:0] ALU_SUB  = 6'd6;
    localparam logic [5:0] ALU_NAND = 6'd7;
    localparam logic [5:0] ALU_NOR  = 6'd12;
    localparam logic [5:0] ALU_XOR  = 6'd13;

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          is_bne;
    logic          mem_err_q;
    logic          r_legal;
    logic [5:0]    r_alu;
    logic          mem_state;
    logic          expire;

    assign mem_err   = mem_err_q;
    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) ||
                       (state == S_MEM_WRITE);
    assign expire    = (WAIT_LIMIT > 0) && mem_state && !mem_ready &&
                       (wait_cnt == CW'(WAIT_LIMIT));

    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        unique case (funct)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h26:   r_alu = ALU_XOR;
            6'h27:   r_alu = ALU_NOR;
            6'h28:   r_alu = ALU_NAND;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        imm_zext   = 1'b0;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            state_nx = S_FETCH;
        end else begin
            unique case (state)
                S_FETCH: begin
                    mem_rd    = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_en    = 1'b1;
                        pc_en    = 1'b1;
                        state_nx = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    unique case (op)
                        6'h00: begin
                            if (r_legal) state_nx = S_EXEC_R;
                            else begin
                                illegal  = 1'b1;
                                state_nx = S_FETCH;
                            end
                        end
                        6'h23, 6'h2B:               state_nx = S_MEM_ADDR;
                        6'h04, 6'h05:               state_nx = S_BRANCH;
                        6'h02:                      state_nx = S_JUMP;
                        6'h08, 6'h0C, 6'h0D, 6'h0E: state_nx = S_EXEC_I;
                        default: begin
                            illegal  = 1'b1;
                            state_nx = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nx  = (op == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_rd = 1'b1;
                    iord   = 1'b1;
                    if (mem_ready) state_nx = S_MEM_WB;
                    else if (expire) state_nx = S_FETCH;
                end
                S_MEM_WB: begin
                    reg_wr     = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_wr = 1'b1;
                    iord   = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_nx   = S_FETCH;
                    end else if (expire) state_nx = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = r_alu;
                    state_nx  = S_R_WB;
                end
                S_R_WB: begin
                    reg_wr     = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    imm_zext  = (op != 6'h08);
                    unique case (op)
                        6'h0C:   alu_op = ALU_AND;
                        6'h0D:   alu_op = ALU_OR;
                        6'h0E:   alu_op = ALU_XOR;
                        default: alu_op = ALU_ADD;
                    endcase
                    state_nx = S_I_WB;
                end
                S_I_WB: begin
                    reg_wr     = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = 2'b01;
                    instr_done = 1'b1;
                    pc_en      = is_bne ? ~zero : zero;
                    state_nx   = S_FETCH;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end

    // Stall counter restarts whenever the FSM moves or the watchdog fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            is_bne    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) is_bne <= (op == 6'h05);
            if (expire) mem_err_q <= 1'b1;
            if (expire || state_nx != state) wait_cnt <= '0;
            else if (WAIT_LIMIT > 0 && mem_state && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: table-driven instruction model
// producing the expected per-cycle control vector, random plus directed.
module tb_mips_multicycle_ctrl;
    localparam int WL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] alu_op;
    logic       alu_src_a, imm_zext, pc_en, ir_en, iord, mem_rd, mem_wr;
    logic       reg_wr, reg_dst, mem_to_reg, instr_done, illegal, mem_err;
    logic [1:0] alu_src_b, pc_src;

    mips_multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_src(pc_src),
        .pc_en(pc_en), .ir_en(ir_en), .iord(iord), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic       zext;
        logic [1:0] pcs;
        logic       pce, ire, iord, rd, wr, rw, rdst, m2r, done, ill;
    } outs_t;

    outs_t act;
    assign act = {alu_op, alu_src_a, alu_src_b, imm_zext, pc_src, pc_en,
                  ir_en, iord, mem_rd, mem_wr, reg_wr, reg_dst,
                  mem_to_reg, instr_done, illegal};

    localparam logic [5:0] R_FN [7] = '{6'h20, 6'h22, 6'h24, 6'h25,
                                        6'h26, 6'h27, 6'h28};
    localparam int         R_AL [7] = '{2, 6, 0, 1, 13, 12, 7};
    localparam logic [5:0] I_OP [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
    localparam int         I_AL [4] = '{2, 0, 1, 13};
    localparam logic [5:0] OPS [11] = '{6'h00, 6'h00, 6'h23, 6'h2B,
                                        6'h04, 6'h05, 6'h02, 6'h08,
                                        6'h0C, 6'h0D, 6'h0E};

    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    function automatic outs_t idle();
        outs_t e = '0;
        e.alu = 6'd2;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic int r_idx(input logic [5:0] f);
        for (int i = 0; i < 7; i++) if (R_FN[i] == f) return i;
        return -1;
    endfunction

    function automatic int i_idx(input logic [5:0] o);
        for (int i = 0; i < 4; i++) if (I_OP[i] == o) return i;
        return -1;
    endfunction

    task automatic cyc(input outs_t e, input logic mr, input logic z,
                       input string tag);
        mem_ready = mr;
        zero = z;
        @(negedge clk);
        checks++;
        assert (act === e) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, act, e);
        end
        checks++;
        assert (mem_err === exp_err) else begin
            errors++;
            $error("FAIL %s mem_err: got %b want %b", tag, mem_err, exp_err);
        end
        @(posedge clk);
        #1;
    endtask

    // kind 0=fetch 1=load 2=store; ok=0 when the watchdog drops it
    task automatic mem_phase(input int kind, input int stalls,
                             output bit ok);
        outs_t e;
        logic  mr;
        ok = 1'b0;
        for (int k = 0; k <= stalls; k++) begin
            mr = (k >= stalls);
            e = idle();
            if (kind == 0) begin
                e.rd = 1'b1; e.src_b = 2'b01; e.pce = mr; e.ire = mr;
            end else if (kind == 1) begin
                e.rd = 1'b1; e.iord = 1'b1;
            end else begin
                e.wr = 1'b1; e.iord = 1'b1; e.done = mr;
            end
            cyc(e, mr, rbit(), kind == 0 ? "fetch" : "mem");
            if (mr) begin
                ok = 1'b1;
                return;
            end
            if (k == WL) begin
                exp_err = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int sf, input int sm);
        outs_t e;
        bit    ok, legal;
        int    ri, ii;
        logic  z;
        op = o;
        funct = f;
        mem_phase(0, sf, ok);
        if (!ok) return;
        ri = r_idx(f);
        ii = i_idx(o);
        legal = (o == 6'h00 && ri >= 0) || ii >= 0 ||
                o inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        e = idle(); e.src_b = 2'b11; e.ill = !legal;
        cyc(e, rbit(), rbit(), "decode");
        if (!legal) return;
        if (o == 6'h00) begin
            e = idle(); e.src_a = 1'b1; e.alu = 6'(R_AL[ri]);
            cyc(e, rbit(), rbit(), "exec_r");
            e = idle(); e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1;
            cyc(e, rbit(), rbit(), "r_wb");
        end else if (ii >= 0) begin
            e = idle(); e.src_a = 1'b1; e.src_b = 2'b10;
            e.alu = 6'(I_AL[ii]); e.zext = (o != 6'h08);
            cyc(e, rbit(), rbit(), "exec_i");
            e = idle(); e.rw = 1'b1; e.done = 1'b1;
            cyc(e, rbit(), rbit(), "i_wb");
        end else if (o == 6'h23 || o == 6'h2B) begin
            e = idle(); e.src_a = 1'b1; e.src_b = 2'b10;
            cyc(e, rbit(), rbit(), "mem_addr");
            mem_phase(o == 6'h23 ? 1 : 2, sm, ok);
            if (ok && o == 6'h23) begin
                e = idle(); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
                cyc(e, rbit(), rbit(), "mem_wb");
            end
        end else if (o == 6'h04 || o == 6'h05) begin
            z = rbit();
            e = idle(); e.src_a = 1'b1; e.alu = 6'd6; e.pcs = 2'b01;
            e.done = 1'b1; e.pce = (o == 6'h05) ? !z : z;
            cyc(e, rbit(), z, "branch");
        end else begin
            e = idle(); e.pcs = 2'b10; e.pce = 1'b1; e.done = 1'b1;
            cyc(e, rbit(), rbit(), "jump");
        end
    endtask

    initial begin
        outs_t    e;
        bit       ok;
        logic [5:0] o, f;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(idle(), 1'b1, 1'b0, "reset");
        rst = 1'b0;

        run_instr(6'h00, 6'h28, 0, 0);
        run_instr(6'h04, 6'h00, 0, 0);
        run_instr(6'h05, 6'h00, 0, 0);
        run_instr(6'h23, 6'h00, 0, 3);
        run_instr(6'h2B, 6'h00, 1, 2);
        run_instr(6'h3F, 6'h00, 0, 0);
        run_instr(6'h00, 6'h21, 0, 0);
        run_instr(6'h02, 6'h00, 0, 0);
        for (int i = 0; i < 4; i++) run_instr(I_OP[i], 6'h00, 0, 0);
        for (int i = 0; i < 7; i++) run_instr(6'h00, R_FN[i], 0, 0);
        run_instr(6'h23, 6'h00, 0, WL);

        run_instr(6'h00, 6'h20, WL + 3, 0);
        run_instr(6'h00, 6'h22, 0, 0);
        run_instr(6'h23, 6'h00, 0, WL + 2);
        run_instr(6'h2B, 6'h00, 0, WL + 1);

        for (int n = 0; n < 250; n++) begin
            int pick;
            pick = $urandom_range(0, 13);
            o = (pick < 11) ? OPS[pick] : 6'($urandom);
            f = ($urandom_range(0, 3) != 0) ? R_FN[$urandom_range(0, 6)]
                                            : 6'($urandom);
            run_instr(o, f,
                      ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6)
                                                   : $urandom_range(0, 2),
                      ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6)
                                                   : $urandom_range(0, 2));
        end

        op = 6'h2B;
        mem_phase(0, 0, ok);
        e = idle(); e.src_b = 2'b11;
        cyc(e, 1'b1, 1'b0, "decode");
        e = idle(); e.src_a = 1'b1; e.src_b = 2'b10;
        cyc(e, 1'b1, 1'b0, "mem_addr");
        rst = 1'b1;
        cyc(idle(), 1'b1, 1'b0, "rst_mid_sw");
        rst = 1'b0;
        exp_err = 1'b0;
        run_instr(6'h00, 6'h25, 0, 0);
        run_instr(6'h05, 6'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
